motion_segment_sequencer: RTL

//  Drives the velocity-load port (set_v / v_val) of one speed_integrator axis from
//  a stream of constant-acceleration segments.

---
 rtl/motion_pkg.sv | 25 ++
 rtl/motion_segment_sequencer_seg_hold_buf.sv | 54 +++++
 rtl/motion_segment_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/motion_pkg.sv
// Shared types for the motion segment path: segment record, sequencer states
// and the acceleration sign-extension helper.
package motion_pkg;

  localparam int VW = 64;
  localparam int AW = 32;
  localparam int TW = 32;

  typedef struct packed {
    logic [VW-1:0] v0;
    logic [AW-1:0] a;
    logic [TW-1:0] ticks;
    logic          keep_v;
  } seg_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  function automatic logic [VW-1:0] sext_acc(input logic [AW-1:0] a);
    return {{(VW-AW){a[AW-1]}}, a};
  endfunction

endpackage

// File: rtl/motion_segment_sequencer_seg_hold_buf.sv
// One-entry valid/ready holding register. Ready is registered; flush empties the
// entry and refuses any handshake offered in the same cycle.
module seg_hold_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_take,
  input  logic         flush
);

  logic         valid_q, valid_d;
  logic         ready_q, ready_d;
  logic [W-1:0] data_q, data_d;
  logic         accept;

  assign in_ready  = ready_q && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // accept needs an empty entry and out_take a full one, so they never coincide
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_take) begin
      valid_d = 1'b0;
    end
    ready_d = !valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/motion_segment_sequencer.sv
// Turns a stream of constant-acceleration segments into per-tick velocity loads
// for one speed_integrator axis, with a one-entry queue for gapless chaining.
module motion_segment_sequencer
  import motion_pkg::*;
#(
  parameter int VW = motion_pkg::VW,
  parameter int AW = motion_pkg::AW,
  parameter int TW = motion_pkg::TW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          seg_valid,
  output logic          seg_ready,
  input  logic [VW-1:0] seg_v0,
  input  logic [AW-1:0] seg_a,
  input  logic [TW-1:0] seg_ticks,
  input  logic          seg_keep_v,
  input  logic          abort,
  input  logic          clr_underrun,
  output logic          set_v,
  output logic [VW-1:0] v_val,
  output logic          busy,
  output logic          seg_done,
  output logic          underrun,
  output logic [15:0]   seg_count
);

  seg_t       seg_in, pend_seg;
  logic       pend_valid, pend_take;

  seq_state_e state_q, state_d;
  logic [VW-1:0] cur_v_q, cur_v_d;
  logic [VW-1:0] acc_q, acc_d;
  logic [TW-1:0] rem_q, rem_d;
  logic          set_v_q, set_v_d;
  logic [VW-1:0] v_val_q, v_val_d;
  logic          busy_q, busy_d;
  logic          seg_done_q, seg_done_d;
  logic          underrun_q, underrun_d;
  logic [15:0]   seg_count_q, seg_count_d;

  logic          load;
  logic [VW-1:0] load_base;
  logic [VW-1:0] adv_v;
  logic          underrun_set;

  assign seg_in = '{v0: seg_v0, a: seg_a, ticks: seg_ticks, keep_v: seg_keep_v};

  seg_hold_buf #(
    .W($bits(seg_t))
  ) u_pend (
    .clk      (clk),
    .reset    (reset),
    .in_valid (seg_valid),
    .in_ready (seg_ready),
    .in_data  (seg_in),
    .out_valid(pend_valid),
    .out_data (pend_seg),
    .out_take (pend_take),
    .flush    (abort)
  );

  // Velocity the profile would command next; a zero-tick segment never advances.
  assign adv_v = (rem_q != '0) ? cur_v_q + acc_q : cur_v_q;

  always_comb begin
    state_d      = state_q;
    cur_v_d      = cur_v_q;
    acc_d        = acc_q;
    rem_d        = rem_q;
    set_v_d      = 1'b0;
    seg_done_d   = 1'b0;
    seg_count_d  = seg_count_q;
    underrun_set = 1'b0;
    pend_take    = 1'b0;
    load         = 1'b0;
    load_base    = cur_v_q;

    if (abort) begin
      state_d = IDLE;
      cur_v_d = '0;
      rem_d   = '0;
      set_v_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          load = pend_valid;
        end
        RUN: begin
          if (rem_q > TW'(1)) begin
            cur_v_d = cur_v_q + acc_q;
            rem_d   = rem_q - TW'(1);
            set_v_d = 1'b1;
          end else begin
            seg_done_d  = 1'b1;
            seg_count_d = seg_count_q + 16'd1;
            if (pend_valid) begin
              load      = 1'b1;
              load_base = adv_v;
            end else begin
              // Hold the last emitted velocity; a profile that ramps out to zero is a clean stop.
              state_d      = IDLE;
              rem_d        = '0;
              underrun_set = (adv_v != '0);
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (load) begin
        pend_take = 1'b1;
        state_d   = RUN;
        cur_v_d   = pend_seg.keep_v ? load_base : pend_seg.v0;
        acc_d     = sext_acc(pend_seg.a);
        rem_d     = pend_seg.ticks;
        set_v_d   = (pend_seg.ticks != '0);
      end
    end

    v_val_d = cur_v_d;
    busy_d  = (state_d == RUN);

    if (underrun_set) begin
      underrun_d = 1'b1;
    end else if (clr_underrun) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_v_q     <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      set_v_q     <= 1'b0;
      v_val_q     <= '0;
      busy_q      <= 1'b0;
      seg_done_q  <= 1'b0;
      underrun_q  <= 1'b0;
      seg_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_v_q     <= cur_v_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      set_v_q     <= set_v_d;
      v_val_q     <= v_val_d;
      busy_q      <= busy_d;
      seg_done_q  <= seg_done_d;
      underrun_q  <= underrun_d;
      seg_count_q <= seg_count_d;
    end
  end

  assign set_v     = set_v_q;
  assign v_val     = v_val_q;
  assign busy      = busy_q;
  assign seg_done  = seg_done_q;
  assign underrun  = underrun_q;
  assign seg_count = seg_count_q;

endmodule
